// File: rtl/fft_pkg.sv
// Shared FFT definitions: FSM states, log2 helper, bit reversal and twiddle ROM generation.
package fft_pkg;

   typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} fft_state_e;

   localparam int TW_MAX_N = 256;
   localparam int TW_IW    = $clog2(TW_MAX_N / 2);

   typedef logic [TW_MAX_N/2-1:0][1:0][31:0] tw_rom_t;

   function automatic int log2n(input int n);
      return $clog2(n);
   endfunction

   function automatic int bit_rev(input int v, input int bits);
      int r;
      r = 0;
      for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
      return r;
   endfunction

   function automatic int rnd_int(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   // Entry i = {sin, cos} of 2*pi*i/n in Q2.(tw_width-2), round to nearest.
   function automatic tw_rom_t tw_rom(input int n, input int tw_width);
      tw_rom_t rom;
      real     ang;
      real     sc;
      rom = '0;
      sc  = 2.0 ** (tw_width - 2);
      for (int i = 0; i < n / 2; i++) begin
         ang       = 2.0 * 3.14159265358979323846 * i / n;
         rom[i][0] = 32'(rnd_int($cos(ang) * sc));
         rom[i][1] = 32'(rnd_int($sin(ang) * sc));
      end
      return rom;
   endfunction

endpackage

// File: rtl/fft_bfly_sat.sv
// Radix-2 DIT butterfly Y0 = A + W*B, Y1 = A - W*B: rounded product, optional /2, saturation.
// Purely combinational; sat is high when any of the four outputs was clipped.
module fft_bfly_sat #(
   parameter int DATA_WIDTH = 16,
   parameter int TW_WIDTH   = 16,
   parameter int SCALE      = 0
) (
   input  logic signed [DATA_WIDTH-1:0] a_re,
   input  logic signed [DATA_WIDTH-1:0] a_im,
   input  logic signed [DATA_WIDTH-1:0] b_re,
   input  logic signed [DATA_WIDTH-1:0] b_im,
   input  logic signed [TW_WIDTH-1:0]   w_re,
   input  logic signed [TW_WIDTH-1:0]   w_im,
   output logic signed [DATA_WIDTH-1:0] y0_re,
   output logic signed [DATA_WIDTH-1:0] y0_im,
   output logic signed [DATA_WIDTH-1:0] y1_re,
   output logic signed [DATA_WIDTH-1:0] y1_im,
   output logic                         sat
);
   localparam int PW = DATA_WIDTH + TW_WIDTH + 1;
   localparam int SW = DATA_WIDTH + 2;
   localparam logic signed [PW-1:0]         RND  = PW'(2 ** (TW_WIDTH - 3));
   localparam logic signed [SW-1:0]         SMAX = SW'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [SW-1:0]         SMIN = SW'(-(2 ** (DATA_WIDTH - 1)));
   localparam logic signed [DATA_WIDTH-1:0] DMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [PW-1:0]         p_re, p_im, pr_re, pr_im;
   logic signed [SW-1:0]         wb_re, wb_im;
   logic signed [SW-1:0]         s_v [4];
   logic signed [DATA_WIDTH-1:0] o_v [4];

   always_comb begin
      p_re  = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
      p_im  = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
      pr_re = (p_re + RND) >>> (TW_WIDTH - 2);
      pr_im = (p_im + RND) >>> (TW_WIDTH - 2);
      // |W| <= 1 keeps the rounded product inside the sum width
      wb_re = SW'(pr_re);
      wb_im = SW'(pr_im);
      s_v[0] = SW'(a_re) + wb_re;
      s_v[1] = SW'(a_im) + wb_im;
      s_v[2] = SW'(a_re) - wb_re;
      s_v[3] = SW'(a_im) - wb_im;
      sat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (SCALE != 0) s_v[i] = (s_v[i] + SW'(1)) >>> 1;
         if (s_v[i] > SMAX) begin
            o_v[i] = DMAX;
            sat    = 1'b1;
         end else if (s_v[i] < SMIN) begin
            o_v[i] = DMIN;
            sat    = 1'b1;
         end else begin
            o_v[i] = DATA_WIDTH'(s_v[i]);
         end
      end
      y0_re = o_v[0];
      y0_im = o_v[1];
      y1_re = o_v[2];
      y1_im = o_v[3];
   end

endmodule

// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed LOAD, one butterfly per cycle, valid/ready UNLOAD.
// First bin (N/2)*log2N+1 cycles after the last input; FFT_RADIX2_ITER_INVERSE_EN adds port inverse.
module fft_radix2_iter
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int N          = 8,
   parameter int TW_WIDTH   = 16,
   parameter int SCALE      = 0
) (
   input  logic                         clk,
   input  logic                         rst,
`ifdef FFT_RADIX2_ITER_INVERSE_EN
   input  logic                         inverse,
`endif
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_real,
   input  logic signed [DATA_WIDTH-1:0] in_imag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_real,
   output logic signed [DATA_WIDTH-1:0] out_imag,
   output logic                         out_last,
   output logic                         busy,
   output logic                         ovf
);
   localparam int      AW = log2n(N);
   localparam int      KW = AW - 1;
   localparam tw_rom_t TW = tw_rom(N, TW_WIDTH);

   fft_state_e state_q, state_d;
   logic [AW-1:0] ld_cnt_q, ld_cnt_d, unl_cnt_q, unl_cnt_d, stage_q, stage_d;
   logic [KW-1:0] k_q, k_d;
   logic          out_vld_q, out_vld_d, ovf_q, ovf_d;
   logic signed [DATA_WIDTH-1:0] re_q [N];
   logic signed [DATA_WIDTH-1:0] re_d [N];
   logic signed [DATA_WIDTH-1:0] im_q [N];
   logic signed [DATA_WIDTH-1:0] im_d [N];

   logic [AW-1:0]                kx, half, top_a, bot_a, tw_full;
   logic [TW_IW-1:0]             tw_i;
   logic signed [TW_WIDTH-1:0]   w_re, w_im, w_sin;
   logic signed [DATA_WIDTH-1:0] y0_re, y0_im, y1_re, y1_im;
   logic                         bf_sat;
`ifdef FFT_RADIX2_ITER_INVERSE_EN
   logic                         inv_q, inv_d;
`endif

   always_comb begin
      kx      = {1'b0, k_q};
      half    = AW'(1) << stage_q;
      top_a   = ((kx >> stage_q) << (stage_q + AW'(1))) | (kx & (half - AW'(1)));
      bot_a   = top_a | half;
      tw_full = (kx & (half - AW'(1))) << (AW'(AW - 1) - stage_q);
      tw_i    = TW_IW'(tw_full);
      w_re    = TW[tw_i][0][TW_WIDTH-1:0];
      w_sin   = TW[tw_i][1][TW_WIDTH-1:0];
`ifdef FFT_RADIX2_ITER_INVERSE_EN
      w_im    = inv_q ? w_sin : -w_sin;
`else
      w_im    = -w_sin;
`endif
   end

   fft_bfly_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .TW_WIDTH   (TW_WIDTH),
      .SCALE      (SCALE)
   ) u_bfly (
      .a_re  (re_q[top_a]),
      .a_im  (im_q[top_a]),
      .b_re  (re_q[bot_a]),
      .b_im  (im_q[bot_a]),
      .w_re  (w_re),
      .w_im  (w_im),
      .y0_re (y0_re),
      .y0_im (y0_im),
      .y1_re (y1_re),
      .y1_im (y1_im),
      .sat   (bf_sat)
   );

   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      unl_cnt_d = unl_cnt_q;
      stage_d   = stage_q;
      k_d       = k_q;
      out_vld_d = 1'b0;
      ovf_d     = ovf_q;
      re_d      = re_q;
      im_d      = im_q;
`ifdef FFT_RADIX2_ITER_INVERSE_EN
      inv_d     = inv_q;
`endif
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               re_d[AW'(bit_rev(int'(ld_cnt_q), AW))] = in_real;
               im_d[AW'(bit_rev(int'(ld_cnt_q), AW))] = in_imag;
               if (ld_cnt_q == '0) begin
                  ovf_d = 1'b0;
`ifdef FFT_RADIX2_ITER_INVERSE_EN
                  inv_d = inverse;
`endif
               end
               if (ld_cnt_q == AW'(N - 1)) begin
                  ld_cnt_d = '0;
                  state_d  = COMPUTE;
               end else begin
                  ld_cnt_d = ld_cnt_q + AW'(1);
               end
            end
         end
         COMPUTE: begin
            re_d[top_a] = y0_re;
            im_d[top_a] = y0_im;
            re_d[bot_a] = y1_re;
            im_d[bot_a] = y1_im;
            if (bf_sat) ovf_d = 1'b1;
            if (k_q == '1) begin
               k_d = '0;
               if (stage_q == AW'(AW - 1)) begin
                  stage_d = '0;
                  state_d = UNLOAD;
               end else begin
                  stage_d = stage_q + AW'(1);
               end
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         UNLOAD: begin
            // out_valid rises one cycle after entry so bin 0 comes from a settled array
            out_vld_d = 1'b1;
            if (out_vld_q && out_ready) begin
               if (unl_cnt_q == AW'(N - 1)) begin
                  unl_cnt_d = '0;
                  out_vld_d = 1'b0;
                  state_d   = LOAD;
               end else begin
                  unl_cnt_d = unl_cnt_q + AW'(1);
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LOAD;
         ld_cnt_q  <= '0;
         unl_cnt_q <= '0;
         stage_q   <= '0;
         k_q       <= '0;
         out_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         unl_cnt_q <= unl_cnt_d;
         stage_q   <= stage_d;
         k_q       <= k_d;
         out_vld_q <= out_vld_d;
         ovf_q     <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      re_q <= re_d;
      im_q <= im_d;
`ifdef FFT_RADIX2_ITER_INVERSE_EN
      inv_q <= inv_d;
`endif
   end

   assign in_ready  = (state_q == LOAD);
   assign busy      = (state_q != LOAD);
   assign out_valid = out_vld_q;
   assign out_last  = out_vld_q && (unl_cnt_q == AW'(N - 1));
   assign out_real  = re_q[unl_cnt_q];
   assign out_imag  = im_q[unl_cnt_q];
   assign ovf       = ovf_q;

endmodule
